// File: rtl/countdown_timer_pkg.sv
// Shared constants for the timer, clock and stopwatch blocks: state codes,
// field selectors, field widths and wrap limits.
package countdown_timer_pkg;

    localparam int HOURS_W   = 5;
    localparam int MINUTES_W = 6;
    localparam int SECONDS_W = 6;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    localparam logic [1:0] FIELD_SEC = 2'd0;
    localparam logic [1:0] FIELD_MIN = 2'd1;
    localparam logic [1:0] FIELD_HR  = 2'd2;

    localparam logic [1:0] ST_SET     = 2'd0;
    localparam logic [1:0] ST_PAUSED  = 2'd1;
    localparam logic [1:0] ST_RUNNING = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    // Field selector advance, 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_field(input logic [1:0] sel);
        return (sel == FIELD_HR) ? FIELD_SEC : sel + 2'd1;
    endfunction

endpackage

// File: rtl/countdown_timer_field.sv
// One wrapping time field (0..MAX) with load, decrement and increment.
// borrow_o flags a decrement out of zero so fields can be chained.
module timer_field #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] value_o,
    output logic             borrow_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (dec_i) begin
            value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
        end else if (inc_i) begin
            value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign borrow_o = dec_i & ~load_i & (value_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Timer-mode control and H:M:S countdown datapath with stored preset,
// driving the display mux with binary fields and status flags.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int HOUR_MAX = 23
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 tick_i,
    input  logic                 set_run_switch_i,
    input  logic                 up_i,
    input  logic                 down_reset_i,
    input  logic                 setmode_runpause_i,
    output logic [HOURS_W-1:0]   hours_o,
    output logic [MINUTES_W-1:0] minutes_o,
    output logic [SECONDS_W-1:0] seconds_o,
    output logic [1:0]           field_sel_o,
    output logic                 running_o,
    output logic                 expired_o
);

    logic [1:0]           state_q, state_d;
    logic [1:0]           field_sel_q, field_sel_d;
    logic                 running_q, running_d;
    logic                 expired_q, expired_d;
    logic [HOURS_W-1:0]   preset_hr_q, preset_hr_d;
    logic [MINUTES_W-1:0] preset_min_q, preset_min_d;
    logic [SECONDS_W-1:0] preset_sec_q, preset_sec_d;

    logic [HOURS_W-1:0]   hours;
    logic [MINUTES_W-1:0] minutes;
    logic [SECONDS_W-1:0] seconds;

    logic       in_set, set_up, set_dn;
    logic [2:0] set_inc, set_dec;
    logic       run_dec, load_time;
    logic       sec_dec, min_dec, hr_dec;
    logic       sec_borrow, min_borrow, hr_borrow;
    logic       time_zero, dec_to_zero;

    // Field controls are decoded outside the state logic so the borrow chain
    // never feeds back into the block that produces it.
    assign in_set = set_run_switch_i & (state_q == ST_SET);
    assign set_dn = in_set & down_reset_i;
    assign set_up = in_set & up_i & ~down_reset_i & ~setmode_runpause_i;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_set_ctrl
            assign set_inc[gi] = set_up & (field_sel_q == 2'(gi));
            assign set_dec[gi] = set_dn & (field_sel_q == 2'(gi));
        end
    endgenerate

    // A reload suppresses the tick decrement in the same cycle.
    assign run_dec   = ~set_run_switch_i & (state_q == ST_RUNNING) & tick_i & ~down_reset_i;
    assign load_time = ~set_run_switch_i & (state_q != ST_SET)
                     & (down_reset_i | (setmode_runpause_i & (state_q == ST_EXPIRED)));

    assign sec_dec = set_dec[0] | run_dec;
    assign min_dec = set_dec[1] | (run_dec & sec_borrow);
    assign hr_dec  = set_dec[2] | (run_dec & min_borrow);

    timer_field #(.WIDTH(SECONDS_W), .MAX(SEC_MAX)) u_sec (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .load_i     (load_time),
        .load_val_i (preset_sec_q),
        .dec_i      (sec_dec),
        .inc_i      (set_inc[0]),
        .value_o    (seconds),
        .borrow_o   (sec_borrow)
    );

    timer_field #(.WIDTH(MINUTES_W), .MAX(MIN_MAX)) u_min (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .load_i     (load_time),
        .load_val_i (preset_min_q),
        .dec_i      (min_dec),
        .inc_i      (set_inc[1]),
        .value_o    (minutes),
        .borrow_o   (min_borrow)
    );

    timer_field #(.WIDTH(HOURS_W), .MAX(HOUR_MAX)) u_hr (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .load_i     (load_time),
        .load_val_i (preset_hr_q),
        .dec_i      (hr_dec),
        .inc_i      (set_inc[2]),
        .value_o    (hours),
        .borrow_o   (hr_borrow)
    );

    assign time_zero   = (hours == '0) && (minutes == '0) && (seconds == '0);
    assign dec_to_zero = (hours == '0) && (minutes == '0) && (seconds == SECONDS_W'(1));

    always_comb begin
        state_d      = state_q;
        field_sel_d  = field_sel_q;
        preset_hr_d  = preset_hr_q;
        preset_min_d = preset_min_q;
        preset_sec_d = preset_sec_q;

        if (set_run_switch_i) begin
            state_d = ST_SET;
            if (state_q == ST_SET && !down_reset_i && setmode_runpause_i) begin
                field_sel_d = next_field(field_sel_q);
            end
        end else begin
            case (state_q)
                ST_SET: begin
                    state_d      = ST_PAUSED;
                    preset_hr_d  = hours;
                    preset_min_d = minutes;
                    preset_sec_d = seconds;
                end
                ST_PAUSED: begin
                    if (!down_reset_i && setmode_runpause_i && !time_zero) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    // An underflow out of hours is treated as expiry too.
                    if (down_reset_i) begin
                        state_d = ST_PAUSED;
                    end else if (run_dec && (dec_to_zero || hr_borrow)) begin
                        state_d = ST_EXPIRED;
                    end else if (setmode_runpause_i) begin
                        state_d = ST_PAUSED;
                    end
                end
                default: begin
                    if (down_reset_i || setmode_runpause_i) begin
                        state_d = ST_PAUSED;
                    end
                end
            endcase
        end

        running_d = (state_d == ST_RUNNING);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= ST_PAUSED;
            field_sel_q  <= FIELD_SEC;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
            preset_hr_q  <= '0;
            preset_min_q <= '0;
            preset_sec_q <= '0;
        end else begin
            state_q      <= state_d;
            field_sel_q  <= field_sel_d;
            running_q    <= running_d;
            expired_q    <= expired_d;
            preset_hr_q  <= preset_hr_d;
            preset_min_q <= preset_min_d;
            preset_sec_q <= preset_sec_d;
        end
    end

    assign hours_o     = hours;
    assign minutes_o   = minutes;
    assign seconds_o   = seconds;
    assign field_sel_o = field_sel_q;
    assign running_o   = running_q;
    assign expired_o   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: set, run, expiry, coincident events,
// hour wrap and asynchronous reset.
module tb_countdown_timer;

    logic       clk_i = 1'b0;
    logic       nreset_i = 1'b0;
    logic       tick_i = 1'b0;
    logic       set_run_switch_i = 1'b0;
    logic       up_i = 1'b0;
    logic       down_reset_i = 1'b0;
    logic       setmode_runpause_i = 1'b0;
    logic [4:0] hours_o;
    logic [5:0] minutes_o;
    logic [5:0] seconds_o;
    logic [1:0] field_sel_o;
    logic       running_o;
    logic       expired_o;

    int tests_run = 0;
    int tests_failed = 0;

    countdown_timer #(.HOUR_MAX(23)) dut (
        .clk_i              (clk_i),
        .nreset_i           (nreset_i),
        .tick_i             (tick_i),
        .set_run_switch_i   (set_run_switch_i),
        .up_i               (up_i),
        .down_reset_i       (down_reset_i),
        .setmode_runpause_i (setmode_runpause_i),
        .hours_o            (hours_o),
        .minutes_o          (minutes_o),
        .seconds_o          (seconds_o),
        .field_sel_o        (field_sel_o),
        .running_o          (running_o),
        .expired_o          (expired_o)
    );

    always #5 clk_i = ~clk_i;

    // Called at a falling edge: hold inputs for one rising edge, then clear.
    task automatic cyc(input logic t, input logic u, input logic d, input logic s);
        tick_i = t; up_i = u; down_reset_i = d; setmode_runpause_i = s;
        @(negedge clk_i);
        tick_i = 1'b0; up_i = 1'b0; down_reset_i = 1'b0; setmode_runpause_i = 1'b0;
        $display("[TB] t=%0t sw=%0b tick=%0b up=%0b dn=%0b sm=%0b -> %0d:%0d:%0d sel=%0d run=%0b exp=%0b",
                 $time, set_run_switch_i, t, u, d, s, hours_o, minutes_o, seconds_o,
                 field_sel_o, running_o, expired_o);
    endtask

    task automatic test_reset;
        set_run_switch_i = 1'b0;
        nreset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        nreset_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", hours_o, minutes_o, seconds_o);
        end
        tests_run++;
        if ({field_sel_o, running_o, expired_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags got sel=%0d run=%0b exp=%0b want 0/0/0", field_sel_o, running_o, expired_o);
        end
        cyc(0, 0, 0, 1);
        tests_run++;
        if ({running_o, hours_o, minutes_o, seconds_o} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_runpause_zero got run=%0b %0d:%0d:%0d want run=0 0:0:0",
                     running_o, hours_o, minutes_o, seconds_o);
        end
    endtask

    task automatic test_set_fields;
        set_run_switch_i = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== {5'd0, 6'd0, 6'd59}) begin
            tests_failed++;
            $display("FAIL set_sec_wrap got %0d:%0d:%0d want 0:0:59", hours_o, minutes_o, seconds_o);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        tests_run++;
        if (field_sel_o !== 2'd2 || hours_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL set_hr_inc got sel=%0d hr=%0d want sel=2 hr=1", field_sel_o, hours_o);
        end
    endtask

    task automatic test_run_reload;
        // From 1:00:59 sel=2 build 0:01:00.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== {5'd0, 6'd1, 6'd0} || field_sel_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL set_0_01_00 got %0d:%0d:%0d sel=%0d want 0:1:0 sel=1",
                     hours_o, minutes_o, seconds_o, field_sel_o);
        end
        set_run_switch_i = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== {5'd0, 6'd0, 6'd59} || running_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL run_borrow got %0d:%0d:%0d run=%0b want 0:0:59 run=1",
                     hours_o, minutes_o, seconds_o, running_o);
        end
        cyc(0, 0, 1, 0);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== {5'd0, 6'd1, 6'd0} || running_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_reload got %0d:%0d:%0d run=%0b want 0:1:0 run=0",
                     hours_o, minutes_o, seconds_o, running_o);
        end
    endtask

    task automatic test_expire;
        set_run_switch_i = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        set_run_switch_i = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        tests_run++;
        if (seconds_o !== 6'd1 || expired_o !== 1'b0 || running_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL expire_first_tick got sec=%0d run=%0b exp=%0b want 1/1/0", seconds_o, running_o, expired_o);
        end
        cyc(1, 0, 0, 0);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== 17'd0 || expired_o !== 1'b1 || running_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL expire_zero got %0d:%0d:%0d run=%0b exp=%0b want 0:0:0 run=0 exp=1",
                     hours_o, minutes_o, seconds_o, running_o, expired_o);
        end
        cyc(1, 1, 0, 0);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== 17'd0 || expired_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL expire_hold got %0d:%0d:%0d exp=%0b want 0:0:0 exp=1",
                     hours_o, minutes_o, seconds_o, expired_o);
        end
        cyc(0, 0, 0, 1);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== {5'd0, 6'd0, 6'd2} || expired_o !== 1'b0 || running_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL expire_clear got %0d:%0d:%0d run=%0b exp=%0b want 0:0:2 run=0 exp=0",
                     hours_o, minutes_o, seconds_o, running_o, expired_o);
        end
    endtask

    task automatic test_coincident;
        set_run_switch_i = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        set_run_switch_i = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        tests_run++;
        if (seconds_o !== 6'd4 || running_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL tick_runpause got sec=%0d run=%0b want sec=4 run=0", seconds_o, running_o);
        end
        cyc(0, 0, 1, 1);
        tests_run++;
        if (seconds_o !== 6'd5 || running_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL down_runpause got sec=%0d run=%0b want sec=5 run=0", seconds_o, running_o);
        end
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        tests_run++;
        if (seconds_o !== 6'd5 || running_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL tick_down got sec=%0d run=%0b want sec=5 run=0", seconds_o, running_o);
        end
    endtask

    task automatic test_hour_wrap;
        set_run_switch_i = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        tests_run++;
        if (hours_o !== 5'd23 || field_sel_o !== 2'd2 || minutes_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL hour_dec_wrap got hr=%0d min=%0d sel=%0d want hr=23 min=0 sel=2",
                     hours_o, minutes_o, field_sel_o);
        end
        cyc(0, 1, 0, 0);
        tests_run++;
        if (hours_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL hour_inc_wrap got hr=%0d want 0", hours_o);
        end
    endtask

    task automatic test_async_reset;
        cyc(0, 0, 1, 0);
        set_run_switch_i = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== {5'd23, 6'd0, 6'd4} || running_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_run got %0d:%0d:%0d run=%0b want 23:0:4 run=1",
                     hours_o, minutes_o, seconds_o, running_o);
        end
        #2;
        tick_i = 1'b1;
        nreset_i = 1'b0;
        #1;
        tests_run++;
        if ({hours_o, minutes_o, seconds_o, field_sel_o, running_o, expired_o} !== 21'd0) begin
            tests_failed++;
            $display("FAIL async_reset got %0d:%0d:%0d sel=%0d run=%0b exp=%0b want all 0",
                     hours_o, minutes_o, seconds_o, field_sel_o, running_o, expired_o);
        end
        @(negedge clk_i);
        tick_i = 1'b0;
        nreset_i = 1'b1;
        cyc(1, 0, 0, 1);
        tests_run++;
        if ({hours_o, minutes_o, seconds_o} !== 17'd0 || running_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_paused got %0d:%0d:%0d run=%0b want 0:0:0 run=0",
                     hours_o, minutes_o, seconds_o, running_o);
        end
    endtask

    initial begin
        test_reset();
        test_set_fields();
        test_run_reload();
        test_expire();
        test_coincident();
        test_hour_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
